// File: rtl/jtcps1_pkg.sv
// Shared CPS1 video definitions: line-buffer geometry, the transparent entry,
// entry field layout and the line-buffer sequencer state/debug types.
package jtcps1_pkg;

  localparam int LB_AW = 9;
  localparam int LB_DW = 11;

  localparam logic [LB_DW-1:0] BLANK_PXL = 11'h00f;

  // Entry layout {group, pal, colour}
  localparam int GROUP_MSB = 10;
  localparam int GROUP_LSB = 9;
  localparam int PAL_MSB   = 8;
  localparam int PAL_LSB   = 4;
  localparam int COL_MSB   = 3;
  localparam int COL_LSB   = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } lb_state_t;

  typedef struct packed {
    lb_state_t st;
    logic      wbank;
    logic      rearm;
  } lb_dbg_t;

  function automatic logic [3:0] lb_col(input logic [LB_DW-1:0] e);
    return e[COL_MSB:COL_LSB];
  endfunction

  function automatic logic [4:0] lb_pal(input logic [LB_DW-1:0] e);
    return e[PAL_MSB:PAL_LSB];
  endfunction

  function automatic logic [1:0] lb_group(input logic [LB_DW-1:0] e);
    return e[GROUP_MSB:GROUP_LSB];
  endfunction

endpackage

// File: rtl/jtcps1_tile_linebuf_if.sv
// Link between the tilemap fetcher and the line buffer: fill control and writes.
//
// Handshake: tm_start is a level held high while a fill is wanted; tm_stop is a
// one-cycle abort; tm_done is honoured only while a fill is running; buf_wr
// commits buf_data at buf_addr in the cycle it is high, with no backpressure.
interface jtcps1_tile_linebuf_if #(
  parameter int AW = 9,
  parameter int DW = 11
);
  logic          tm_start;
  logic          tm_stop;
  logic          tm_done;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_data;
  logic          buf_wr;

  modport master (
    input  tm_start, tm_stop,
    output tm_done, buf_addr, buf_data, buf_wr
  );

  modport slave (
    output tm_start, tm_stop,
    input  tm_done, buf_addr, buf_data, buf_wr
  );
endinterface

// File: rtl/jtcps1_lbram.sv
// One line-buffer bank: simple dual-port RAM, one write port, registered read.
module jtcps1_lbram #(
  parameter int AW = 9,
  parameter int DW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/jtcps1_tile_linebuf.sv
// Double-buffered scanline store for one CPS1 scroll layer: the fetcher fills
// one bank while the other streams to the mixer and is erased behind the read.
module jtcps1_tile_linebuf
  import jtcps1_pkg::*;
#(
  parameter int            AW    = LB_AW,
  parameter int            DW    = LB_DW,
  parameter logic [DW-1:0] BLANK = BLANK_PXL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flip,
  input  logic                  line_start,
  input  logic                  pxl_cen,
  input  logic [AW-1:0]         hdump,
  jtcps1_tile_linebuf_if.slave  fbus,
  output logic [DW-1:0]         pxl,
  output logic                  overrun,
  output lb_dbg_t               dbg
);

  lb_state_t st;
  logic      wbank;
  logic      tm_start_r;
  logic      tm_stop_r;
  logic      rearm;
  logic      clean;

  assign fbus.tm_start = tm_start_r;
  assign fbus.tm_stop  = tm_stop_r;
  assign dbg           = '{st: st, wbank: wbank, rearm: rearm};

  // clean marks that the current fill was started without aborting a late one;
  // only a done from such a fill clears overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= ST_IDLE;
      wbank      <= 1'b0;
      tm_start_r <= 1'b0;
      tm_stop_r  <= 1'b0;
      rearm      <= 1'b0;
      clean      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      tm_stop_r <= 1'b0;
      rearm     <= 1'b0;
      if (line_start) wbank <= ~wbank;
      if (rearm) tm_start_r <= 1'b1;
      case (st)
        ST_IDLE: begin
          if (line_start) begin
            st         <= ST_BUSY;
            tm_start_r <= 1'b1;
            clean      <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (line_start && !fbus.tm_done) begin
            tm_stop_r  <= 1'b1;
            tm_start_r <= 1'b0;
            rearm      <= 1'b1;
            overrun    <= 1'b1;
            clean      <= 1'b0;
          end else if (line_start) begin
            tm_start_r <= 1'b1;
            if (clean) overrun <= 1'b0;
            clean <= 1'b1;
          end else if (fbus.tm_done && !rearm) begin
            st         <= ST_IDLE;
            tm_start_r <= 1'b0;
            if (clean) overrun <= 1'b0;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // Read pipe: c0 captures address and bank, c1 reads the RAM, c2 updates pxl
  // and erases the entry in the bank captured at c0.
  logic [AW-1:0] rd_addr;
  logic          rd_bank;
  logic          rd_v1;
  logic          rd_v2;
  logic [DW-1:0] rd_q [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      rd_bank <= 1'b0;
      rd_v1   <= 1'b0;
      rd_v2   <= 1'b0;
      pxl     <= BLANK;
    end else begin
      rd_v1 <= pxl_cen;
      rd_v2 <= rd_v1;
      if (pxl_cen) begin
        rd_addr <= hdump ^ {AW{flip}};
        rd_bank <= ~wbank;
      end
      if (rd_v2) pxl <= rd_bank ? rd_q[1] : rd_q[0];
    end
  end

  // An erase wins the bank write port; a fetcher write only meets it there
  // when a swap happens mid-read, which the timing of hblank makes harmless.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic SEL = (b == 1);
    logic erase;
    logic fill;

    assign erase = rd_v2 && (rd_bank == SEL);
    assign fill  = fbus.buf_wr && (wbank == SEL);

    jtcps1_lbram #(.AW(AW), .DW(DW)) u_ram (
      .clk   (clk),
      .we    (erase | fill),
      .waddr (erase ? rd_addr : fbus.buf_addr),
      .wdata (erase ? BLANK : fbus.buf_data),
      .re    (rd_v1 && (rd_bank == SEL)),
      .raddr (rd_addr),
      .q     (rd_q[b])
    );
  end

endmodule

// File: tb/tb_jtcps1_tile_linebuf.sv
// Bench for jtcps1_tile_linebuf: two-bank line model, read-erase scoreboard and
// fetcher sequencing scenarios.
module tb_jtcps1_tile_linebuf;
  import jtcps1_pkg::*;

  localparam logic [10:0] BLK = 11'h00f;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flip = 1'b0;
  logic        line_start = 1'b0;
  logic        pxl_cen = 1'b0;
  logic [8:0]  hdump = '0;
  logic [10:0] pxl;
  logic        overrun;
  lb_dbg_t     dbg;

  jtcps1_tile_linebuf_if #(.AW(9), .DW(11)) fbus ();

  jtcps1_tile_linebuf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flip       (flip),
    .line_start (line_start),
    .pxl_cen    (pxl_cen),
    .hdump      (hdump),
    .fbus       (fbus),
    .pxl        (pxl),
    .overrun    (overrun),
    .dbg        (dbg)
  );

  always #5 clk = ~clk;

  // Reference: two whole-line arrays and which one the fetcher is filling
  logic [10:0] bank_m [2][512];
  logic        mw;
  logic [10:0] last_pxl;
  logic        last_known;
  logic [10:0] exp_q [$];
  logic [8:0]  wr_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [8:0] a, input logic [10:0] d);
    fbus.buf_addr = a;
    fbus.buf_data = d;
    fbus.buf_wr   = 1'b1;
    tick();
    fbus.buf_wr = 1'b0;
    bank_m[mw][a] = d;
    wr_q.push_back(a);
  endtask

  task automatic fetch_done;
    fbus.tm_done = 1'b1;
    tick();
    fbus.tm_done = 1'b0;
  endtask

  task automatic line_pulse;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    mw = ~mw;
  endtask

  function automatic logic [8:0] phys(input logic [8:0] x);
    return flip ? (x ^ 9'h1ff) : x;
  endfunction

  // One isolated read: pxl must hold through c1 and carry the entry after c2
  task automatic read_px(input logic [8:0] x, input bit chk, input string nm);
    logic [8:0]  a;
    logic        rb;
    logic [10:0] got;
    a  = phys(x);
    rb = ~mw;
    exp_q.push_back(bank_m[rb][a]);
    bank_m[rb][a] = BLK;
    hdump   = x;
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    hdump   = 9'($urandom);
    tick();
    if (chk && last_known) begin
      n_cmp++;
      if (pxl !== last_pxl) begin
        n_err++;
        $display("FAIL %s_hold: x=%h pxl=%h required %h", nm, x, pxl, last_pxl);
      end
    end
    tick();
    got = exp_q.pop_front();
    if (chk) begin
      n_cmp++;
      if (pxl !== got) begin
        n_err++;
        $display("FAIL %s: x=%h flip=%b pxl=%h required %h", nm, x, flip, pxl, got);
      end
    end
    last_pxl   = got;
    last_known = chk;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (fbus.tm_start !== 1'b0 || fbus.tm_stop !== 1'b0 || pxl !== BLK ||
        overrun !== 1'b0 || dbg.wbank !== 1'b0 || dbg.st !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset: start=%b stop=%b pxl=%h ovr=%b wbank=%b st=%0d required 0 0 00f 0 0 0",
               fbus.tm_start, fbus.tm_stop, pxl, overrun, dbg.wbank, dbg.st);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_erase_pass;
    for (int p = 0; p < 3; p++) begin
      line_pulse();
      for (int x = 0; x < 512; x++) read_px(9'(x), p == 2, "erase_pass");
      fetch_done();
    end
  endtask

  task automatic test_fill_read;
    write_px(9'h040, 11'h5a3);
    fetch_done();
    line_pulse();
    n_cmp++;
    if (bank_m[~mw][9'h040] !== 11'h5a3 || last_pxl === 11'h5a3) begin
      n_err++;
      $display("FAIL fill_setup: model=%h required 5a3", bank_m[~mw][9'h040]);
    end
    read_px(9'h040, 1'b1, "fill_read");
    fetch_done();
    line_pulse();
    line_pulse();
    read_px(9'h040, 1'b1, "fill_reread");
  endtask

  task automatic test_flip;
    write_px(9'h1bf, 11'h2c7);
    fetch_done();
    line_pulse();
    flip = 1'b1;
    read_px(9'h040, 1'b1, "flip_read");
    read_px(9'h040, 1'b1, "flip_reread");
    flip = 1'b0;
  endtask

  task automatic test_abort;
    fetch_done();
    n_cmp++;
    if (dbg.st !== ST_IDLE || fbus.tm_start !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle: st=%0d start=%b required 0 0", dbg.st, fbus.tm_start);
    end
    line_pulse();
    n_cmp++;
    if (dbg.st !== ST_BUSY || fbus.tm_start !== 1'b1 || fbus.tm_stop !== 1'b0) begin
      n_err++;
      $display("FAIL abort_go: st=%0d start=%b stop=%b required 1 1 0", dbg.st, fbus.tm_start, fbus.tm_stop);
    end
    tick();
    line_pulse();
    n_cmp++;
    if (fbus.tm_stop !== 1'b1 || fbus.tm_start !== 1'b0 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL abort_stop: stop=%b start=%b ovr=%b required 1 0 1", fbus.tm_stop, fbus.tm_start, overrun);
    end
    tick();
    n_cmp++;
    if (fbus.tm_stop !== 1'b0 || fbus.tm_start !== 1'b1 || dbg.st !== ST_BUSY) begin
      n_err++;
      $display("FAIL abort_rearm: stop=%b start=%b st=%0d required 0 1 1", fbus.tm_stop, fbus.tm_start, dbg.st);
    end
    tick();
    n_cmp++;
    if (fbus.tm_stop !== 1'b0 || fbus.tm_start !== 1'b1 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL abort_hold: stop=%b start=%b ovr=%b required 0 1 1", fbus.tm_stop, fbus.tm_start, overrun);
    end
    fetch_done();
    n_cmp++;
    if (fbus.tm_start !== 1'b0 || dbg.st !== ST_IDLE || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL abort_done: start=%b st=%0d ovr=%b required 0 0 1", fbus.tm_start, dbg.st, overrun);
    end
    fetch_done();
    n_cmp++;
    if (fbus.tm_start !== 1'b0 || dbg.st !== ST_IDLE) begin
      n_err++;
      $display("FAIL idle_done: start=%b st=%0d required 0 0", fbus.tm_start, dbg.st);
    end
    line_pulse();
    n_cmp++;
    if (fbus.tm_start !== 1'b1 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL clean_go: start=%b ovr=%b required 1 1", fbus.tm_start, overrun);
    end
    fetch_done();
    n_cmp++;
    if (fbus.tm_start !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL clean_done: start=%b ovr=%b required 0 0", fbus.tm_start, overrun);
    end
  endtask

  task automatic test_wr_at_swap;
    fbus.buf_addr = 9'h010;
    fbus.buf_data = 11'h123;
    fbus.buf_wr   = 1'b1;
    line_start    = 1'b1;
    tick();
    fbus.buf_wr = 1'b0;
    line_start  = 1'b0;
    bank_m[mw][9'h010] = 11'h123;
    mw = ~mw;
    fetch_done();
    read_px(9'h010, 1'b1, "wr_at_swap");
  endtask

  task automatic test_random;
    logic [8:0] x;
    for (int l = 0; l < 6; l++) begin
      flip = 1'($urandom_range(0, 1));
      wr_q.delete();
      for (int k = 0; k < 24; k++) write_px(9'($urandom_range(0, 511)), 11'($urandom_range(0, 2047)));
      fetch_done();
      line_pulse();
      for (int k = 0; k < 24; k++) begin
        if (k % 2 == 0) x = phys(wr_q[$urandom_range(0, wr_q.size() - 1)]);
        else            x = 9'($urandom_range(0, 511));
        read_px(x, 1'b1, "rand_rd");
      end
    end
    flip = 1'b0;
  endtask

  // Reads every second clock, the tightest legal spacing, with repeats
  task automatic test_back_to_back;
    logic [8:0]  x;
    logic [8:0]  a;
    logic [10:0] e;
    wr_q.delete();
    for (int k = 0; k < 16; k++) write_px(9'($urandom_range(0, 511)), 11'($urandom_range(0, 2047)));
    fetch_done();
    line_pulse();
    x = 9'h000;
    for (int k = 0; k < 32; k++) begin
      if (k % 4 != 1) x = wr_q[$urandom_range(0, wr_q.size() - 1)];
      a = phys(x);
      exp_q.push_back(bank_m[~mw][a]);
      bank_m[~mw][a] = BLK;
      hdump   = x;
      pxl_cen = 1'b1;
      tick();
      pxl_cen = 1'b0;
      if (k > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (pxl !== e) begin
          n_err++;
          $display("FAIL b2b_rd: k=%0d pxl=%h required %h", k - 1, pxl, e);
        end
      end
      tick();
    end
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (pxl !== e) begin
      n_err++;
      $display("FAIL b2b_last: pxl=%h required %h", pxl, e);
    end
    last_pxl = e;
    last_known = 1'b1;
  endtask

  task automatic test_reset_busy;
    write_px(9'h0a5, 11'h6ee);
    fetch_done();
    line_pulse();
    read_px(9'h0a5, 1'b1, "pre_rst_rd");
    line_pulse();
    hdump   = 9'h0a5;
    pxl_cen = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (fbus.tm_start !== 1'b0 || pxl !== BLK || dbg.wbank !== 1'b0 ||
        dbg.st !== ST_IDLE || overrun !== 1'b0 || fbus.tm_stop !== 1'b0) begin
      n_err++;
      $display("FAIL rst_busy: start=%b pxl=%h wbank=%b st=%0d ovr=%b stop=%b required 0 00f 0 0 0 0",
               fbus.tm_start, pxl, dbg.wbank, dbg.st, overrun, fbus.tm_stop);
    end
    tick();
    rst_n   = 1'b1;
    pxl_cen = 1'b0;
    mw      = 1'b0;
    last_pxl   = BLK;
    last_known = 1'b1;
    tick();
    n_cmp++;
    if (pxl !== BLK || fbus.tm_start !== 1'b0 || dbg.wbank !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release: pxl=%h start=%b wbank=%b required 00f 0 0", pxl, fbus.tm_start, dbg.wbank);
    end
    wr_q.delete();
    for (int k = 0; k < 8; k++) write_px(9'($urandom_range(0, 511)), 11'($urandom_range(0, 2047)));
    fetch_done();
    line_pulse();
    for (int k = 0; k < 8; k++) read_px(wr_q[k], 1'b1, "post_rst_rd");
  endtask

  initial begin
    fbus.tm_done  = 1'b0;
    fbus.buf_wr   = 1'b0;
    fbus.buf_addr = '0;
    fbus.buf_data = '0;
    mw         = 1'b0;
    last_pxl   = BLK;
    last_known = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 512; i++) bank_m[b][i] = BLK;
    test_reset();
    test_erase_pass();
    test_fill_read();
    test_flip();
    test_abort();
    test_wr_at_swap();
    test_random();
    test_back_to_back();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
